// File: rtl/sys_defs.sv
// Shared address-generation definitions: access sizes, the default queue entry
// layout and the natural-alignment rule used by the AGU.
package sys_defs;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } MEM_SIZE;

  localparam int unsigned AGU_XLEN  = 32;
  localparam int unsigned AGU_TAG_W = 6;

  typedef struct packed {
    logic [AGU_XLEN-1:0]  addr;
    MEM_SIZE              size;
    logic [AGU_TAG_W-1:0] tag;
    logic                 misaligned;
  } AGU_ENTRY;

  // Only the three low address bits matter for sizes up to a double word.
  function automatic logic misaligned_f(input logic [2:0] addr_lo, input MEM_SIZE size);
    logic mis_s;
    case (size)
      MEM_BYTE:   mis_s = 1'b0;
      MEM_HALF:   mis_s = addr_lo[0];
      MEM_WORD:   mis_s = |addr_lo[1:0];
      MEM_DOUBLE: mis_s = |addr_lo;
      default:    mis_s = 1'b0;
    endcase
    return mis_s;
  endfunction

endpackage

// File: rtl/agu_fifo.sv
// Synchronous FIFO of arbitrary entry type; depth need not be a power of two.
// Pushes into a full queue and pops from an empty queue are ignored.
module agu_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; clear empties the queue in one edge.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Storage write; contents behind the pointers need no reset.
  always_ff @(posedge clock) begin
    if (do_push_s && reset && !clear) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/agu_pipe.sv
// Pipelined address-generation unit: base+offset with alignment check, carried
// through LAT never-stalling stages into a credit-protected output queue.
module agu_pipe
  import sys_defs::*;
#(
  parameter int  XLEN   = 32,
  parameter int  TAG_W  = 6,
  parameter int  LAT    = 2,
  parameter int  QDEPTH = 4,
  localparam int IW     = $clog2(QDEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_offset,
  input  logic [1:0]       in_size,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_addr,
  output logic [1:0]       out_size,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_misaligned,
  output logic [IW-1:0]    inflight
);

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    MEM_SIZE          size;
    logic [TAG_W-1:0] tag;
    logic             misaligned;
  } entry_t;

  logic            live_s;
  logic            accept_s;
  logic            pop_s;
  logic            push_s;
  logic [IW-1:0]   inflight_r;
  logic [XLEN-1:0] comp_addr_s;
  entry_t          comp_ent_s;
  entry_t          head_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [IW-1:0]   fifo_count_s;

  // Credits are checked against the registered count, so a same-cycle pop
  // only frees a slot on the following cycle.
  assign live_s    = reset && !flush;
  assign in_ready  = live_s && (inflight_r < IW'(QDEPTH)) && !fifo_full_s;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = live_s && (fifo_count_s != '0);
  assign pop_s     = out_valid && out_ready;
  assign inflight  = inflight_r;

  // Stage-0 compute: wrapping add and natural-alignment test.
  always_comb begin
    comp_addr_s           = in_base + in_offset;
    comp_ent_s            = '0;
    comp_ent_s.addr       = comp_addr_s;
    comp_ent_s.size       = MEM_SIZE'(in_size);
    comp_ent_s.tag        = in_tag;
    comp_ent_s.misaligned = misaligned_f(comp_addr_s[2:0], MEM_SIZE'(in_size));
  end

  for (genvar g = 0; g < LAT; g++) begin : g_stage
    logic   vld_r;
    entry_t ent_r;
    logic   vld_d_s;
    entry_t ent_d_s;

    if (g == 0) begin : g_head
      assign vld_d_s = accept_s;
      assign ent_d_s = comp_ent_s;
    end else begin : g_tail
      assign vld_d_s = g_stage[g-1].vld_r;
      assign ent_d_s = g_stage[g-1].ent_r;
    end

    // Stage register; advances every cycle, squashed by flush or reset.
    always_ff @(posedge clock) begin
      if (!reset || flush) begin
        vld_r <= 1'b0;
        ent_r <= '0;
      end else begin
        vld_r <= vld_d_s;
        ent_r <= ent_d_s;
      end
    end
  end

  assign push_s = g_stage[LAT-1].vld_r && live_s;

  agu_fifo #(
    .DEPTH(QDEPTH),
    .T    (entry_t)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .clear(flush),
    .push (push_s),
    .pop  (pop_s),
    .din  (g_stage[LAT-1].ent_r),
    .dout (head_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s),
    .count(fifo_count_s)
  );

  // Occupancy across pipeline and queue: +1 per accept, -1 per pop.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      inflight_r <= '0;
    end else begin
      inflight_r <= inflight_r + IW'(accept_s) - IW'(pop_s);
    end
  end

  // Head fields read as zero whenever the queue holds nothing.
  always_comb begin
    out_addr       = '0;
    out_size       = 2'd0;
    out_tag        = '0;
    out_misaligned = 1'b0;
    if (!fifo_empty_s) begin
      out_addr       = head_s.addr;
      out_size       = head_s.size;
      out_tag        = head_s.tag;
      out_misaligned = head_s.misaligned;
    end else begin
      out_addr       = '0;
      out_size       = 2'd0;
      out_tag        = '0;
      out_misaligned = 1'b0;
    end
  end

endmodule

// File: tb/tb_agu_pipe.sv
// Bench for agu_pipe: two instances (QDEPTH=3 and QDEPTH=4, LAT=2) share one
// stimulus stream and are checked against a timestamped scoreboard model.
module tb_agu_pipe;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [5:0]  tag;
    logic        mis;
    int          arr;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] off;
    logic [1:0]  size;
    logic [5:0]  tag;
    logic [31:0] addr;
    logic        mis;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_base, in_offset;
  logic [1:0]  in_size;
  logic [5:0]  in_tag;

  logic        o_iready [2];
  logic        o_ovalid [2];
  logic        o_mis    [2];
  logic [31:0] o_addr   [2];
  logic [1:0]  o_size   [2];
  logic [5:0]  o_tag    [2];
  logic [1:0]  infl_a;
  logic [2:0]  infl_b;

  logic        s_iready [2];
  logic        s_ovalid [2];
  logic        s_mis    [2];
  logic [31:0] s_addr   [2];
  logic [5:0]  s_tag    [2];
  int          s_infl   [2];
  logic        acc_w    [2];
  logic        pop_w    [2];

  exp_t sb [2][$];
  vec_t tbl [11];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  agu_pipe #(.XLEN(32), .TAG_W(6), .LAT(LAT), .QDEPTH(3)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_iready[0]),
    .in_base(in_base), .in_offset(in_offset), .in_size(in_size), .in_tag(in_tag),
    .out_valid(o_ovalid[0]), .out_ready(out_ready),
    .out_addr(o_addr[0]), .out_size(o_size[0]), .out_tag(o_tag[0]),
    .out_misaligned(o_mis[0]), .inflight(infl_a)
  );

  agu_pipe #(.XLEN(32), .TAG_W(6), .LAT(LAT), .QDEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(o_iready[1]),
    .in_base(in_base), .in_offset(in_offset), .in_size(in_size), .in_tag(in_tag),
    .out_valid(o_ovalid[1]), .out_ready(out_ready),
    .out_addr(o_addr[1]), .out_size(o_size[1]), .out_tag(o_tag[1]),
    .out_misaligned(o_mis[1]), .inflight(infl_b)
  );

  function automatic int qd(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, expected 0x%0h", nm, inst, cyc, act, req);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic do_cycle(input logic rst, input logic v, input logic [31:0] b, input logic [31:0] o,
                          input logic [1:0] s, input logic [5:0] t, input logic ordy, input logic fl);
    logic hv, ev, erdy;
    exp_t e;
    reset = rst; flush = fl; in_valid = v; in_base = b; in_offset = o;
    in_size = s; in_tag = t; out_ready = ordy;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      s_iready[i] = o_iready[i];
      s_ovalid[i] = o_ovalid[i];
      s_addr[i]   = o_addr[i];
      s_tag[i]    = o_tag[i];
      s_mis[i]    = o_mis[i];
      s_infl[i]   = (i == 0) ? int'(infl_a) : int'(infl_b);
      hv   = (sb[i].size() > 0) && (sb[i][0].arr <= cyc);
      ev   = hv && rst && !fl;
      erdy = rst && !fl && (sb[i].size() < qd(i));
      chk("in_ready", i, 32'(s_iready[i]), 32'(erdy));
      chk("out_valid", i, 32'(s_ovalid[i]), 32'(ev));
      chk("inflight", i, s_infl[i], sb[i].size());
      if (ev) begin
        chk("out_addr", i, s_addr[i], sb[i][0].addr);
        chk("out_size", i, 32'(o_size[i]), 32'(sb[i][0].size));
        chk("out_tag", i, 32'(s_tag[i]), 32'(sb[i][0].tag));
        chk("out_mis", i, 32'(s_mis[i]), 32'(sb[i][0].mis));
      end else if (!hv) begin
        chk("idle_addr", i, s_addr[i], 32'h0);
        chk("idle_tag", i, 32'(s_tag[i]), 32'h0);
      end
      acc_w[i] = erdy && v;
      pop_w[i] = ev && ordy;
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst || fl) begin
        sb[i].delete();
      end else begin
        if (pop_w[i]) void'(sb[i].pop_front());
        if (acc_w[i]) begin
          e.addr = b + o;
          e.size = s;
          e.tag  = t;
          e.mis  = ((b + o) % (32'd1 << s)) != 32'd0;
          e.arr  = cyc + LAT;
          sb[i].push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 6'd0, ordy, 1'b0);
  endtask

  // Single request into an empty unit: nothing for LAT edges, then the result.
  task automatic run_vec(input vec_t vv, input string nm);
    do_cycle(1'b1, 1'b1, vv.base, vv.off, vv.size, vv.tag, 1'b0, 1'b0);
    for (int k = 0; k < LAT; k++) begin
      do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 6'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) chk({nm, "_early"}, i, 32'(s_ovalid[i]), 32'h0);
    end
    do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_valid"}, i, 32'(s_ovalid[i]), 32'h1);
      chk({nm, "_addr"}, i, s_addr[i], vv.addr);
      chk({nm, "_mis"}, i, 32'(s_mis[i]), 32'(vv.mis));
      chk({nm, "_tag"}, i, 32'(s_tag[i]), 32'(vv.tag));
    end
  endtask

  initial begin
    int   acc_cnt [2];
    int   pop_cnt [2];
    vec_t vv;
    logic [5:0] nt;

    tbl[0]  = '{32'h00001000, 32'hFFFFFFFC, 2'd2, 6'd5,  32'h00000FFC, 1'b0};
    tbl[1]  = '{32'h00002001, 32'h00000000, 2'd0, 6'd1,  32'h00002001, 1'b0};
    tbl[2]  = '{32'h00002001, 32'h00000000, 2'd1, 6'd2,  32'h00002001, 1'b1};
    tbl[3]  = '{32'h00002001, 32'h00000000, 2'd2, 6'd3,  32'h00002001, 1'b1};
    tbl[4]  = '{32'h00002001, 32'h00000000, 2'd3, 6'd4,  32'h00002001, 1'b1};
    tbl[5]  = '{32'h00002004, 32'h00000000, 2'd3, 6'd6,  32'h00002004, 1'b1};
    tbl[6]  = '{32'h00002004, 32'h00000000, 2'd2, 6'd7,  32'h00002004, 1'b0};
    tbl[7]  = '{32'hFFFFFFFF, 32'h00000001, 2'd0, 6'd8,  32'h00000000, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 32'h00000001, 2'd3, 6'd9,  32'h00000000, 1'b0};
    tbl[9]  = '{32'h00003000, 32'h00000002, 2'd1, 6'd10, 32'h00003002, 1'b0};
    tbl[10] = '{32'h00000000, 32'h00000006, 2'd3, 6'd63, 32'h00000006, 1'b1};

    // Reset: held low for a few cycles with traffic offered.
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1, 32'h10, 32'h4, 2'd2, 6'd1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(s_iready[i]), 32'h0);
      chk("rst_infl", i, s_infl[i], 0);
    end
    idle(1, 1'b1);
    for (int i = 0; i < 2; i++) chk("post_rst_ready", i, 32'(s_iready[i]), 32'h1);

    foreach (tbl[k]) run_vec(tbl[k], "vec");

    // Backpressure: consumer stalled, requests offered continuously.
    acc_cnt = '{0, 0};
    pop_cnt = '{0, 0};
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'($urandom), 6'(k), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) acc_cnt[i] += int'(acc_w[i]);
    end
    for (int i = 0; i < 2; i++) begin
      chk("bp_accepts", i, acc_cnt[i], qd(i));
      chk("bp_ready", i, 32'(s_iready[i]), 32'h0);
      chk("bp_infl", i, s_infl[i], qd(i));
    end
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 6'd0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) if (pop_w[i]) begin
        chk("bp_order", i, 32'(s_tag[i]), pop_cnt[i]);
        pop_cnt[i]++;
      end
    end
    for (int i = 0; i < 2; i++) chk("bp_drained", i, pop_cnt[i], qd(i));

    // Streaming: the QDEPTH=4 instance sustains one request per cycle.
    acc_cnt = '{0, 0};
    pop_cnt = '{0, 0};
    for (int k = 0; k < 20; k++) begin
      do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'($urandom), 6'(k), 1'b1, 1'b0);
      acc_cnt[1] += int'(acc_w[1]);
      if (pop_w[1]) pop_cnt[1]++;
    end
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 6'd0, 1'b1, 1'b0);
      if (pop_w[1]) pop_cnt[1]++;
    end
    chk("stream_accepts", 1, acc_cnt[1], 20);
    chk("stream_pops", 1, pop_cnt[1], 20);

    // Flush with requests spread over pipeline and queue.
    for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'd0, 6'(6'h30 + k), 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h0, 32'h0, 2'd0, 6'h3F, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("flush_valid", i, 32'(s_ovalid[i]), 32'h0);
      chk("flush_infl", i, s_infl[i], 0);
    end
    idle(3, 1'b1);
    vv = '{32'h00000040, 32'h00000004, 2'd2, 6'h2A, 32'h00000044, 1'b0};
    run_vec(vv, "post_flush");

    // Reset wins over a simultaneous flush.
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'd1, 6'(k), 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 6'd0, 1'b1, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 2; i++) chk("rst_flush_infl", i, s_infl[i], 0);

    // Mixed random traffic: pointer wrap, occasional flush and reset.
    nt = 6'd0;
    for (int k = 0; k < 300; k++) begin
      do_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
               2'($urandom), nt, ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
      nt = nt + 6'd1;
    end
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
